// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_pkg;

    // Frame-collection and command-issue states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DHI   = 3'd2,
        DLO   = 3'd3,
        CSUM  = 3'd4,
        ISSUE = 3'd5
    } state_t;

    // ERR_CODE values, held on the output until the next error
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    // Status bytes returned to the host when echo is built in
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // Frame checksum: plain XOR of address, data high and data low
    function automatic logic [7:0] frame_csum(input logic [7:0] a,
                                              input logic [7:0] h,
                                              input logic [7:0] l);
        return a ^ h ^ l;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: load/clear down-counter that strobes o_expire after TIMEOUT_CYCLES-1 idle counting cycles.
// Latency: o_expire is combinational from the count; the loaded value means "0 cycles elapsed".
// Backpressure: none; i_load always wins, the count parks at zero and never wraps.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 27000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Reload on every clear request, otherwise count down while enabled and hold at zero
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= LOAD_VAL;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Collects 5-byte host frames (sync, addr, data hi, data lo, xor checksum) and issues one register write per good frame.
// Latency: CMD_VALID rises on the edge after the checksum byte; ERR strobes on the edge that detects the fault.
// Backpressure: command held stable until CMD_VALID&CMD_READY; bytes arriving while holding are dropped as overrun.
// Build option: define UART_CMD_ECHO_EN to add the ACK/NAK status echo (TX_DATA, TX_START, TX_BUSY).
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 27000,
    parameter int         CNT_W          = 8
) (
`ifdef UART_CMD_ECHO_EN
    output logic [7:0]       TX_DATA,
    output logic             TX_START,
    input  logic             TX_BUSY,
`endif
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_READY,
    output logic             CMD_VALID,
    input  logic             CMD_READY,
    output logic [7:0]       CMD_ADDR,
    output logic [15:0]      CMD_DATA,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output logic [CNT_W-1:0] ERR_CNT
);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_addr;
    logic [7:0]         r_hi;
    logic [7:0]         r_lo;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               w_err_set;
    logic [1:0]         w_err_code;
    logic               w_timed;
    logic               w_to_load;
    logic               w_expire;

    // Only the four mid-frame states are subject to the inter-byte watchdog
    assign w_timed   = (r_state == ADDR) || (r_state == DHI) || (r_state == DLO) || (r_state == CSUM);
    // Restart the watchdog on every byte, on every state change, and whenever it is not guarding a frame
    assign w_to_load = RX_READY || (w_next != r_state) || !w_timed;

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_load   (w_to_load),
        .i_en     (w_timed),
        .o_expire (w_expire)
    );

    // State register; reset discards any partial frame or pending command
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and error decode; a byte arriving on the expiry cycle beats the timeout
    always_comb begin
        w_next     = r_state;
        w_err_set  = 1'b0;
        w_err_code = ERR_CSUM;
        case (r_state)
            IDLE: begin
                if (RX_READY && (RX_DATA == SYNC_BYTE)) w_next = ADDR;
            end
            ADDR, DHI, DLO: begin
                if (RX_READY) begin
                    w_next = (r_state == ADDR) ? DHI : ((r_state == DHI) ? DLO : CSUM);
                end else if (w_expire) begin
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                    w_next     = IDLE;
                end
            end
            CSUM: begin
                if (RX_READY) begin
                    if (RX_DATA == frame_csum(r_addr, r_hi, r_lo)) begin
                        w_next = ISSUE;
                    end else begin
                        w_err_set  = 1'b1;
                        w_err_code = ERR_CSUM;
                        w_next     = IDLE;
                    end
                end else if (w_expire) begin
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                    w_next     = IDLE;
                end
            end
            ISSUE: begin
                if (RX_READY) begin
                    w_err_set  = 1'b1;
                    w_err_code = ERR_OVERRUN;
                end
                if (CMD_READY) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Payload latches; only written mid-frame, so they stay frozen while the command is offered
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_addr <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (RX_READY) begin
            case (r_state)
                ADDR:    r_addr <= RX_DATA;
                DHI:     r_hi   <= RX_DATA;
                DLO:     r_lo   <= RX_DATA;
                default: ;
            endcase
        end
    end

    // Error strobe, sticky code and saturating count
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_err_cnt  <= '0;
        end else begin
            r_err <= w_err_set;
            if (w_err_set) begin
                r_err_code <= w_err_code;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign CMD_VALID = (r_state == ISSUE);
    assign CMD_ADDR  = r_addr;
    assign CMD_DATA  = {r_hi, r_lo};
    assign ERR       = r_err;
    assign ERR_CODE  = r_err_code;
    assign ERR_CNT   = r_err_cnt;

`ifdef UART_CMD_ECHO_EN
    logic       r_tx_full;
    logic [7:0] r_tx_hold;
    logic [7:0] r_tx_data;
    logic       r_tx_start;
    logic       w_accept;
    logic       w_status_vld;
    logic [7:0] w_status_byte;

    assign w_accept      = CMD_VALID && CMD_READY;
    assign w_status_vld  = w_accept || w_err_set;
    // An error in the same cycle as an acceptance is the more useful news for the host
    assign w_status_byte = w_err_set ? NAK_BYTE : ACK_BYTE;

    // One-entry status holder: newest status overwrites, launch waits for an idle transmitter
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_tx_full  <= 1'b0;
            r_tx_hold  <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            if (r_tx_full && !TX_BUSY && !r_tx_start) begin
                r_tx_start <= 1'b1;
                r_tx_data  <= r_tx_hold;
                r_tx_full  <= 1'b0;
            end
            if (w_status_vld) begin
                r_tx_full <= 1'b1;
                r_tx_hold <= w_status_byte;
            end
        end
    end

    assign TX_DATA  = r_tx_data;
    assign TX_START = r_tx_start;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized frames against a frame-level model.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled there or on the falling edge.
// Backpressure: CMD_READY driven per scenario; every wait is bounded.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

    localparam int TO = 200;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_READY = 1'b0;
    logic        CMD_READY = 1'b0;
    logic        CMD_VALID;
    logic [7:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        ERR;
    logic [1:0]  ERR_CODE;
    logic [7:0]  ERR_CNT;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int exp_cnt      = 0;

    logic [23:0] got_cmd[$];
    logic [1:0]  got_err[$];

    uart_cmd_ctrl #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_DATA   (RX_DATA),
        .RX_READY  (RX_READY),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Observe completed transfers and error strobes mid-cycle
    always @(negedge CLK) begin
        if (RST) begin
            if (CMD_VALID && CMD_READY) got_cmd.push_back({CMD_ADDR, CMD_DATA});
            if (ERR) got_err.push_back(ERR_CODE);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xsum(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
        return a ^ h ^ l;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(h);
        send_byte(l);
        send_byte(c);
    endtask

    task automatic test_reset();
        RST = 1'b0; CMD_READY = 1'b0; RX_READY = 1'b0;
        idle(2);
        exp_cnt = 0;
        tests_run++; if (CMD_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", CMD_VALID); end
        tests_run++; if (CMD_ADDR !== 8'h00) begin tests_failed++; $display("FAIL reset_addr got %h want 00", CMD_ADDR); end
        tests_run++; if (CMD_DATA !== 16'h0000) begin tests_failed++; $display("FAIL reset_data got %h want 0000", CMD_DATA); end
        tests_run++; if (ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", ERR); end
        tests_run++; if (ERR_CODE !== 2'b00) begin tests_failed++; $display("FAIL reset_code got %b want 00", ERR_CODE); end
        tests_run++; if (ERR_CNT !== 8'h00) begin tests_failed++; $display("FAIL reset_cnt got %h want 00", ERR_CNT); end
        RST = 1'b1;
        step();
    endtask

    task automatic test_good_frame();
        got_cmd.delete(); got_err.delete();
        CMD_READY = 1'b1;
        send_frame(8'h48, 8'h01, 8'hE0, 8'hA9);
        tests_run++; if (CMD_VALID !== 1'b1) begin tests_failed++; $display("FAIL good_valid got %b want 1", CMD_VALID); end
        tests_run++; if (CMD_ADDR !== 8'h48) begin tests_failed++; $display("FAIL good_addr got %h want 48", CMD_ADDR); end
        tests_run++; if (CMD_DATA !== 16'h01E0) begin tests_failed++; $display("FAIL good_data got %h want 01e0", CMD_DATA); end
        step();
        tests_run++; if (CMD_VALID !== 1'b0) begin tests_failed++; $display("FAIL good_valid_drop got %b want 0", CMD_VALID); end
        idle(2);
        tests_run++; if (got_cmd.size() != 1) begin tests_failed++; $display("FAIL good_xfers got %0d want 1", got_cmd.size()); end
        tests_run++; if (got_err.size() != 0) begin tests_failed++; $display("FAIL good_errs got %0d want 0", got_err.size()); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int unstable = 0;
        int k = 0;
        got_cmd.delete(); got_err.delete();
        CMD_READY = 1'b0;
        send_frame(8'h48, 8'h01, 8'hE0, 8'hA9);
        for (int i = 0; i < 10; i++) begin
            if (CMD_VALID) n++;
            if (CMD_ADDR !== 8'h48 || CMD_DATA !== 16'h01E0) unstable++;
            step();
        end
        CMD_READY = 1'b1;
        while (CMD_VALID && k < 50) begin
            n++;
            if (CMD_ADDR !== 8'h48 || CMD_DATA !== 16'h01E0) unstable++;
            step();
            k++;
        end
        CMD_READY = 1'b0;
        idle(2);
        tests_run++; if (n != 11) begin tests_failed++; $display("FAIL bp_valid_cycles got %0d want 11", n); end
        tests_run++; if (unstable != 0) begin tests_failed++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
        tests_run++; if (got_cmd.size() != 1) begin tests_failed++; $display("FAIL bp_xfers got %0d want 1", got_cmd.size()); end
    endtask

    task automatic test_bad_csum();
        RST = 1'b0; step(); RST = 1'b1;
        exp_cnt = 0;
        got_cmd.delete(); got_err.delete();
        CMD_READY = 1'b1;
        send_frame(8'h48, 8'h01, 8'hE0, 8'hAA);
        exp_cnt = sat_inc(exp_cnt);
        tests_run++; if (ERR !== 1'b1) begin tests_failed++; $display("FAIL csum_err got %b want 1", ERR); end
        tests_run++; if (ERR_CODE !== 2'b01) begin tests_failed++; $display("FAIL csum_code got %b want 01", ERR_CODE); end
        tests_run++; if (ERR_CNT !== 8'(exp_cnt)) begin tests_failed++; $display("FAIL csum_cnt got %0d want %0d", ERR_CNT, exp_cnt); end
        tests_run++; if (CMD_VALID !== 1'b0) begin tests_failed++; $display("FAIL csum_valid got %b want 0", CMD_VALID); end
        step();
        tests_run++; if (ERR !== 1'b0) begin tests_failed++; $display("FAIL csum_err_pulse got %b want 0", ERR); end
        idle(3);
        tests_run++; if (got_cmd.size() != 0) begin tests_failed++; $display("FAIL csum_xfers got %0d want 0", got_cmd.size()); end
    endtask

    task automatic test_timeout();
        int c0;
        int k = 0;
        got_cmd.delete(); got_err.delete();
        CMD_READY = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h48);
        c0 = cyc;
        while (!ERR && k < TO + 20) begin step(); k++; end
        exp_cnt = sat_inc(exp_cnt);
        tests_run++; if (ERR !== 1'b1) begin tests_failed++; $display("FAIL to_seen got %b want 1 within %0d cycles", ERR, TO + 20); end
        tests_run++; if (cyc - c0 != TO) begin tests_failed++; $display("FAIL to_delay got %0d want %0d", cyc - c0, TO); end
        tests_run++; if (ERR_CODE !== 2'b10) begin tests_failed++; $display("FAIL to_code got %b want 10", ERR_CODE); end
        tests_run++; if (ERR_CNT !== 8'(exp_cnt)) begin tests_failed++; $display("FAIL to_cnt got %0d want %0d", ERR_CNT, exp_cnt); end
        step();
        send_frame(8'h12, 8'h34, 8'h56, 8'h70);
        tests_run++; if (CMD_VALID !== 1'b1 || CMD_ADDR !== 8'h12 || CMD_DATA !== 16'h3456) begin
            tests_failed++; $display("FAIL to_recover got v=%b %h/%h want 1 12/3456", CMD_VALID, CMD_ADDR, CMD_DATA); end
        step();
        // a byte landing on the last permitted cycle must be taken, not timed out
        send_byte(8'hA5);
        send_byte(8'h48);
        idle(TO - 1);
        send_byte(8'h01);
        tests_run++; if (ERR !== 1'b0) begin tests_failed++; $display("FAIL to_byte_wins got ERR=%b want 0", ERR); end
        send_byte(8'hE0);
        send_byte(8'hA9);
        tests_run++; if (CMD_VALID !== 1'b1 || CMD_DATA !== 16'h01E0) begin
            tests_failed++; $display("FAIL to_edge_frame got v=%b %h want 1 01e0", CMD_VALID, CMD_DATA); end
        step();
        tests_run++; if (got_err.size() != 1) begin tests_failed++; $display("FAIL to_err_total got %0d want 1", got_err.size()); end
    endtask

    task automatic test_back_to_back();
        got_cmd.delete(); got_err.delete();
        CMD_READY = 1'b1;
        send_frame(8'h11, 8'h22, 8'h33, xsum(8'h11, 8'h22, 8'h33));
        step();
        send_frame(8'h44, 8'h55, 8'h66, xsum(8'h44, 8'h55, 8'h66));
        idle(3);
        tests_run++; if (got_cmd.size() != 2) begin tests_failed++; $display("FAIL b2b_xfers got %0d want 2", got_cmd.size()); end
        else begin
            tests_run++; if (got_cmd[0] !== 24'h112233) begin tests_failed++; $display("FAIL b2b_first got %h want 112233", got_cmd[0]); end
            tests_run++; if (got_cmd[1] !== 24'h445566) begin tests_failed++; $display("FAIL b2b_second got %h want 445566", got_cmd[1]); end
        end
        tests_run++; if (got_err.size() != 0) begin tests_failed++; $display("FAIL b2b_errs got %0d want 0", got_err.size()); end
    endtask

    task automatic test_overrun_noise();
        got_cmd.delete(); got_err.delete();
        CMD_READY = 1'b0;
        send_byte(8'h00);
        send_byte(8'hFF);
        step();
        tests_run++; if (got_err.size() != 0 || ERR_CNT !== 8'(exp_cnt)) begin
            tests_failed++; $display("FAIL noise_ignored got errs=%0d cnt=%0d want 0/%0d", got_err.size(), ERR_CNT, exp_cnt); end
        send_frame(8'h48, 8'h01, 8'hE0, 8'hA9);
        send_byte(8'h55);
        exp_cnt = sat_inc(exp_cnt);
        tests_run++; if (ERR !== 1'b1 || ERR_CODE !== 2'b11) begin
            tests_failed++; $display("FAIL ovr_err got %b/%b want 1/11", ERR, ERR_CODE); end
        tests_run++; if (CMD_VALID !== 1'b1 || CMD_ADDR !== 8'h48 || CMD_DATA !== 16'h01E0) begin
            tests_failed++; $display("FAIL ovr_cmd got v=%b %h/%h want 1 48/01e0", CMD_VALID, CMD_ADDR, CMD_DATA); end
        for (int i = 0; i < 260; i++) begin
            send_byte(8'($urandom));
            exp_cnt = sat_inc(exp_cnt);
            if (exp_cnt == 254 || i == 259) begin
                tests_run++; if (ERR_CNT !== 8'(exp_cnt)) begin
                    tests_failed++; $display("FAIL sat_cnt got %0d want %0d", ERR_CNT, exp_cnt); end
            end
        end
        CMD_READY = 1'b1;
        step();
        CMD_READY = 1'b0;
        step();
        tests_run++; if (got_cmd.size() != 1 || (got_cmd.size() == 1 && got_cmd[0] !== 24'h4801E0)) begin
            tests_failed++; $display("FAIL ovr_xfer got n=%0d want one 4801e0", got_cmd.size()); end
    endtask

    task automatic test_reset_midframe();
        CMD_READY = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h48);
        send_byte(8'h01);
        RST = 1'b0;
        step();
        RST = 1'b1;
        exp_cnt = 0;
        tests_run++; if (ERR_CNT !== 8'h00 || CMD_ADDR !== 8'h00 || CMD_VALID !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_clear got cnt=%h addr=%h v=%b want 00/00/0", ERR_CNT, CMD_ADDR, CMD_VALID); end
        got_cmd.delete(); got_err.delete();
        send_frame(8'h12, 8'h34, 8'h56, 8'h70);
        tests_run++; if (CMD_VALID !== 1'b1 || CMD_ADDR !== 8'h12 || CMD_DATA !== 16'h3456) begin
            tests_failed++; $display("FAIL rst_mid_frame got v=%b %h/%h want 1 12/3456", CMD_VALID, CMD_ADDR, CMD_DATA); end
        idle(2);
        tests_run++; if (got_err.size() != 0) begin tests_failed++; $display("FAIL rst_mid_errs got %0d want 0", got_err.size()); end
    endtask

    task automatic test_random();
        logic [23:0] exp_cmd[$];
        logic [1:0]  exp_err[$];
        logic [7:0]  fb[4];
        logic [7:0]  nb;
        int          hold;
        bit          bad;
        int          k;
        got_cmd.delete(); got_err.delete();
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb);
                idle($urandom_range(0, 3));
            end
            fb[0] = 8'($urandom); fb[1] = 8'($urandom); fb[2] = 8'($urandom);
            bad   = ($urandom_range(0, 3) == 0);
            fb[3] = xsum(fb[0], fb[1], fb[2]) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
            hold  = $urandom_range(0, 4);
            CMD_READY = (hold == 0);
            send_byte(8'hA5);
            for (int b = 0; b < 4; b++) begin
                idle(($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 6));
                send_byte(fb[b]);
            end
            if (bad) begin
                exp_err.push_back(2'b01);
                exp_cnt = sat_inc(exp_cnt);
            end else begin
                exp_cmd.push_back({fb[0], fb[1], fb[2]});
                idle(hold);
                CMD_READY = 1'b1;
                k = 0;
                while (CMD_VALID && k < 20) begin step(); k++; end
                if (k >= 20) begin
                    tests_run++; tests_failed++;
                    $display("FAIL rand_accept frame %0d got VALID held 20 cycles want drop", f);
                end
            end
            CMD_READY = 1'($urandom_range(0, 1));
        end
        idle(3);
        tests_run++; if (got_cmd.size() != exp_cmd.size()) begin
            tests_failed++; $display("FAIL rand_xfers got %0d want %0d", got_cmd.size(), exp_cmd.size()); end
        else begin
            for (int i = 0; i < exp_cmd.size(); i++) begin
                tests_run++; if (got_cmd[i] !== exp_cmd[i]) begin
                    tests_failed++; $display("FAIL rand_cmd[%0d] got %h want %h", i, got_cmd[i], exp_cmd[i]); end
            end
        end
        tests_run++; if (got_err.size() != exp_err.size()) begin
            tests_failed++; $display("FAIL rand_errs got %0d want %0d", got_err.size(), exp_err.size()); end
        else begin
            for (int i = 0; i < exp_err.size(); i++) begin
                tests_run++; if (got_err[i] !== exp_err[i]) begin
                    tests_failed++; $display("FAIL rand_err[%0d] got %b want %b", i, got_err[i], exp_err[i]); end
            end
        end
        tests_run++; if (ERR_CNT !== 8'(exp_cnt)) begin
            tests_failed++; $display("FAIL rand_cnt got %0d want %0d", ERR_CNT, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_backpressure();
        test_bad_csum();
        test_timeout();
        test_back_to_back();
        test_overrun_noise();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
